game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DEATH_FRAMES, default 30: frames spent in DYING before OVER.
REQ-002 Parameter OVER_HOLD, default 60: frames in OVER during which the button is ignored.
REQ-003 Parameter PIPE_W, default 80: pipe width in pixels.
REQ-004 Parameter SCORE_MAX, default 999: score saturation value.
REQ-005 clk  in  1  system clock.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-008 btn_flap  in  1  flap button level, already synchronised to clk, active-high.
REQ-009 collision  in  1  registered collision flag from the collision detector.
REQ-010 bird_x  in  12  bird left edge, pixels.
REQ-011 pipe1_x, pipe2_x  in  12 each  pipe left edges, pixels.
REQ-012 state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-013 play_en  out  1  high only in PLAY; enables bird physics and pipe scrolling.
REQ-014 flap_pulse  out  1  one-cycle flap command to the bird controller.
REQ-015 score  out  10  current score, binary.
REQ-016 high_score  out  10  best score since reset, binary.
REQ-017 game_over  out  1  high in OVER.

Function
REQ-018 Button edge: btn_prev SHALL be registered every cycle; press = btn_flap & ~btn_prev.
REQ-019 IDLE: on press -> PLAY next cycle; score cleared to 0; flap_pulse=1 in that same cycle.
REQ-020 PLAY: collision=1 in any cycle -> DYING next cycle, regardless of frame_tick.
REQ-021 PLAY: press with collision=0 -> flap_pulse=1 for exactly that cycle, registered output; held button produces no further pulses.
REQ-022 PLAY: collision and press in the same cycle -> collision wins; no flap_pulse.
REQ-023 Scoring, PLAY only, evaluated on frame_tick: for each pipe, right_n = pipe_n_x + PIPE_W, computed 13-bit with no wrap; ahead_n = (right_n > bird_x), registered per pipe.
REQ-024 A 1->0 transition of ahead_n between consecutive frame_ticks SHALL add 1 to score; a 0->1 transition (pipe respawn at right edge) SHALL add nothing.
REQ-025 Both pipes passing on the same frame_tick SHALL add 2; score saturates at SCORE_MAX, never wraps.
REQ-026 On entry to PLAY, ahead_n flags SHALL be loaded from the current pipe positions so that no spurious score is added.
REQ-027 Scoring SHALL be frozen in DYING, OVER and IDLE; score is held.
REQ-028 DYING: a frame counter counts frame_ticks; after DEATH_FRAMES ticks -> OVER; button and collision ignored.
REQ-029 OVER entry: high_score <= score if score > high_score, else unchanged; the frame counter is cleared.
REQ-030 OVER: presses are ignored until OVER_HOLD frame_ticks have elapsed; then a press -> IDLE; score held until the next IDLE->PLAY.
REQ-031 game_over = (state==OVER); play_en = (state==PLAY); both decoded from registered state.
REQ-032 high_score is cleared only by rst_n, never by a restart.

Reset
REQ-033 While rst_n=0: state=IDLE, flap_pulse=0, score=0, high_score=0, frame counter=0, btn_prev=0, ahead flags=0.
REQ-034 Reset asserted mid-operation (any state) SHALL return to IDLE immediately with all values above; no flap_pulse on release.
REQ-035 After rst_n release, a button already held high SHALL NOT count as a press until it is released and pressed again.

Verification
REQ-036 Reset, btn_flap 0->1 -> state IDLE->PLAY, flap_pulse one cycle, score=0, play_en=1.
REQ-037 PLAY, bird_x=200, pipe1_x stepping 125,122,119 on frame_ticks (right edge 205,202,199) -> score 0->1 on the third tick only; pipe1_x jump to 1280 -> no increment.
REQ-038 PLAY, both pipes crossing on the same tick with score=998 -> score=999 (saturated); at 999, further crossing -> stays 999.
REQ-039 PLAY, collision=1 and press in the same cycle -> DYING, no flap_pulse; after 30 frame_ticks -> OVER, game_over=1, high_score=score if larger.
REQ-040 OVER: press at frame 10 -> ignored; press after 60 frame_ticks -> IDLE; next press -> PLAY with score=0, high_score retained.
REQ-041 rst_n pulsed low during DYING -> IDLE, score=0, high_score=0, game_over=0 asynchronously.

Source files
------------

// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and the rest of the game.
// The slave side is the controller; the master side is the game environment.
interface game_ctrl_if;
    logic        frame_tick;
    logic        btn_flap;
    logic        collision;
    logic [11:0] bird_x;
    logic [11:0] pipe1_x;
    logic [11:0] pipe2_x;
    logic [1:0]  state;
    logic        play_en;
    logic        flap_pulse;
    logic [9:0]  score;
    logic [9:0]  high_score;
    logic        game_over;

    modport master (
        output frame_tick, btn_flap, collision, bird_x, pipe1_x, pipe2_x,
        input  state, play_en, flap_pulse, score, high_score, game_over
    );

    modport slave (
        input  frame_tick, btn_flap, collision, bird_x, pipe1_x, pipe2_x,
        output state, play_en, flap_pulse, score, high_score, game_over
    );
endinterface

// File: rtl/game_ctrl.sv
// Game flow controller: IDLE/PLAY/DYING/OVER sequencing, flap edge detection,
// pipe-pass scoring with saturation and high-score tracking.
module game_ctrl #(
    parameter int DEATH_FRAMES = 30,
    parameter int OVER_HOLD    = 60,
    parameter int PIPE_W       = 80,
    parameter int SCORE_MAX    = 999
) (
    input  logic        clk,
    input  logic        rst_n,
    game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int CNT_MAX = (DEATH_FRAMES > OVER_HOLD) ? DEATH_FRAMES : OVER_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_r, state_nxt_s;
    logic               flap_pulse_r, flap_nxt_s;
    logic               play_en_r, game_over_r;
    logic [9:0]         score_r, score_nxt_s;
    logic [9:0]         high_r, high_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic               ahead1_r, ahead2_r, ahead1_nxt_s, ahead2_nxt_s;
    logic               btn_prev_r;
    logic               btn_armed_r;

    logic               press_s;
    logic [12:0]        right1_s, right2_s;
    logic               ahead1_s, ahead2_s;
    logic [1:0]         pass_cnt_s;
    logic [10:0]        score_sum_s;
    logic [9:0]         score_sat_s;

    // A button held through reset release stays disarmed until it is seen low.
    assign press_s = bus.btn_flap & ~btn_prev_r & btn_armed_r;

    // Right edges are formed in 13 bits so a pipe near the screen limit cannot wrap.
    assign right1_s    = {1'b0, bus.pipe1_x} + 13'(PIPE_W);
    assign right2_s    = {1'b0, bus.pipe2_x} + 13'(PIPE_W);
    assign ahead1_s    = (right1_s > {1'b0, bus.bird_x});
    assign ahead2_s    = (right2_s > {1'b0, bus.bird_x});
    assign pass_cnt_s  = {1'b0, ahead1_r & ~ahead1_s} + {1'b0, ahead2_r & ~ahead2_s};
    assign score_sum_s = {1'b0, score_r} + {9'd0, pass_cnt_s};
    assign score_sat_s = (score_sum_s > 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum_s[9:0];

    // Next-state and next-value logic for the game flow.
    always_comb begin
        state_nxt_s  = state_r;
        flap_nxt_s   = 1'b0;
        score_nxt_s  = score_r;
        high_nxt_s   = high_r;
        cnt_nxt_s    = cnt_r;
        ahead1_nxt_s = ahead1_r;
        ahead2_nxt_s = ahead2_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s) begin
                    state_nxt_s  = ST_PLAY;
                    flap_nxt_s   = 1'b1;
                    score_nxt_s  = 10'd0;
                    ahead1_nxt_s = ahead1_s;
                    ahead2_nxt_s = ahead2_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (bus.frame_tick) begin
                    score_nxt_s  = score_sat_s;
                    ahead1_nxt_s = ahead1_s;
                    ahead2_nxt_s = ahead2_s;
                end else begin
                    score_nxt_s  = score_r;
                end
                // Collision outranks a simultaneous press.
                if (bus.collision) begin
                    state_nxt_s = ST_DYING;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (press_s) begin
                    flap_nxt_s  = 1'b1;
                end else begin
                    flap_nxt_s  = 1'b0;
                end
            end
            ST_DYING: begin
                if (bus.frame_tick) begin
                    if (cnt_r == CNT_W'(DEATH_FRAMES - 1)) begin
                        state_nxt_s = ST_OVER;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                        high_nxt_s  = (score_r > high_r) ? score_r : high_r;
                    end else begin
                        cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_OVER: begin
                if (press_s && (cnt_r == CNT_W'(OVER_HOLD))) begin
                    state_nxt_s = ST_IDLE;
                end else if (bus.frame_tick && (cnt_r < CNT_W'(OVER_HOLD))) begin
                    cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            flap_pulse_r <= 1'b0;
            play_en_r    <= 1'b0;
            game_over_r  <= 1'b0;
            score_r      <= 10'd0;
            high_r       <= 10'd0;
            cnt_r        <= {CNT_W{1'b0}};
            ahead1_r     <= 1'b0;
            ahead2_r     <= 1'b0;
            btn_prev_r   <= 1'b0;
            btn_armed_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            flap_pulse_r <= flap_nxt_s;
            play_en_r    <= (state_nxt_s == ST_PLAY);
            game_over_r  <= (state_nxt_s == ST_OVER);
            score_r      <= score_nxt_s;
            high_r       <= high_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ahead1_r     <= ahead1_nxt_s;
            ahead2_r     <= ahead2_nxt_s;
            btn_prev_r   <= bus.btn_flap;
            btn_armed_r  <= btn_armed_r | ~bus.btn_flap;
        end
    end

    assign bus.state      = state_r;
    assign bus.play_en    = play_en_r;
    assign bus.game_over  = game_over_r;
    assign bus.flap_pulse = flap_pulse_r;
    assign bus.score      = score_r;
    assign bus.high_score = high_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: directed scenarios plus randomized play,
// checked every cycle against a rule-level model of the game.
module tb_game_ctrl;
    localparam int DEATH_FRAMES = 30;
    localparam int OVER_HOLD    = 60;
    localparam int PIPE_W       = 80;
    localparam int SCORE_MAX    = 999;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    game_ctrl_if bus_if();

    game_ctrl #(
        .DEATH_FRAMES (DEATH_FRAMES),
        .OVER_HOLD    (OVER_HOLD),
        .PIPE_W       (PIPE_W),
        .SCORE_MAX    (SCORE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; int pe; int fp; int sc; int hs; int go;
    } exp_t;

    exp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    // Rule-level model: phase, score, best, frames spent in phase, bird-past-pipe flags.
    int m_phase, m_score, m_high, m_ticks;
    bit m_pulse, m_prev, m_seen_low, m_past1, m_past2;

    int bx = 200, p1 = 1000, p2 = 1000;

    task automatic model_reset();
        m_phase = 0; m_score = 0; m_high = 0; m_ticks = 0;
        m_pulse = 0; m_prev = 0; m_seen_low = 0; m_past1 = 0; m_past2 = 0;
    endtask

    task automatic model_step(input bit btn, input bit tick, input bit col,
                              input int x, input int q1, input int q2);
        bit rose, past1, past2;
        int gain;
        rose = btn && !m_prev && m_seen_low;
        m_prev = btn;
        if (!btn) m_seen_low = 1;
        past1 = (q1 + PIPE_W) <= x;
        past2 = (q2 + PIPE_W) <= x;
        m_pulse = 0;
        case (m_phase)
            0: if (rose) begin
                m_phase = 1; m_score = 0; m_pulse = 1;
                m_past1 = past1; m_past2 = past2;
            end
            1: begin
                if (tick) begin
                    gain = ((past1 && !m_past1) ? 1 : 0) + ((past2 && !m_past2) ? 1 : 0);
                    m_score = (m_score + gain > SCORE_MAX) ? SCORE_MAX : m_score + gain;
                    m_past1 = past1; m_past2 = past2;
                end
                if (col) begin m_phase = 2; m_ticks = 0; end
                else if (rose) m_pulse = 1;
            end
            2: if (tick) begin
                m_ticks++;
                if (m_ticks == DEATH_FRAMES) begin
                    m_phase = 3; m_ticks = 0;
                    if (m_score > m_high) m_high = m_score;
                end
            end
            default: begin
                if (rose && m_ticks >= OVER_HOLD) m_phase = 0;
                else if (tick) m_ticks++;
            end
        endcase
    endtask

    task automatic push_exp();
        exp_t e;
        e.st = m_phase; e.pe = (m_phase == 1) ? 1 : 0; e.go = (m_phase == 3) ? 1 : 0;
        e.fp = m_pulse ? 1 : 0; e.sc = m_score; e.hs = m_high;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit btn, input bit tick, input bit col);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.btn_flap = btn; bus_if.frame_tick = tick; bus_if.collision = col;
        bus_if.bird_x = 12'(bx); bus_if.pipe1_x = 12'(p1); bus_if.pipe2_x = 12'(p2);
        model_step(btn, tick, col, bx, p1, p2);
        push_exp();
    endtask

    task automatic do_reset(input bit btn, input int ncyc, input bit async_chk);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            bus_if.btn_flap = btn; bus_if.frame_tick = 1'b0; bus_if.collision = 1'b0;
            if (async_chk && i == 0) begin
                #1;
                check_const("async_rst_state", int'(bus_if.state), 0);
                check_const("async_rst_score", int'(bus_if.score), 0);
                check_const("async_rst_high", int'(bus_if.high_score), 0);
                check_const("async_rst_game_over", int'(bus_if.game_over), 0);
            end
            model_reset();
            push_exp();
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_const(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: each clock the DUT presents a new output vector, compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (int'(bus_if.state) != e.st || int'(bus_if.play_en) != e.pe ||
                    int'(bus_if.flap_pulse) != e.fp || int'(bus_if.score) != e.sc ||
                    int'(bus_if.high_score) != e.hs || int'(bus_if.game_over) != e.go) begin
                    fails++;
                    $display("FAIL outputs @%0t: got st=%0d pe=%0d fp=%0d sc=%0d hs=%0d go=%0d, required st=%0d pe=%0d fp=%0d sc=%0d hs=%0d go=%0d",
                             $time, bus_if.state, bus_if.play_en, bus_if.flap_pulse, bus_if.score,
                             bus_if.high_score, bus_if.game_over, e.st, e.pe, e.fp, e.sc, e.hs, e.go);
                end
            end
        end
    end

    initial begin
        bit b;
        bus_if.btn_flap = 1'b0; bus_if.frame_tick = 1'b0; bus_if.collision = 1'b0;
        bus_if.bird_x = 12'd200; bus_if.pipe1_x = 12'd1000; bus_if.pipe2_x = 12'd1000;
        model_reset();

        // Reset with the button held; it must not start a game on release.
        do_reset(1'b1, 3, 1'b0);
        step(1, 0, 0); step(1, 0, 0);
        settle();
        check_const("held_btn_no_start", int'(bus_if.state), 0);
        step(0, 0, 0);
        p1 = 125; p2 = 1000;
        step(1, 0, 0);
        settle();
        check_const("start_state", int'(bus_if.state), 1);
        check_const("start_flap", int'(bus_if.flap_pulse), 1);
        check_const("start_play_en", int'(bus_if.play_en), 1);
        step(1, 0, 0); step(1, 0, 0);

        // Pipe1 right edge 205, 202, 199 against bird at 200.
        step(1, 1, 0); step(1, 0, 0);
        settle(); check_const("pass_tick1", int'(bus_if.score), 0);
        p1 = 122; step(1, 1, 0); step(0, 0, 0);
        settle(); check_const("pass_tick2", int'(bus_if.score), 0);
        p1 = 119; step(0, 1, 0); step(0, 0, 0);
        settle(); check_const("pass_tick3", int'(bus_if.score), 1);
        p1 = 1280; step(0, 1, 0); step(0, 0, 0);
        settle(); check_const("respawn_no_add", int'(bus_if.score), 1);

        // Drive score up to 998 with double crossings, then saturate.
        for (int i = 0; i < 498; i++) begin
            p1 = 300; p2 = 300; step(0, 1, 0);
            p1 = 100; p2 = 100; step(0, 1, 0);
        end
        p1 = 300; p2 = 300; step(0, 1, 0);
        p1 = 100; step(0, 1, 0);
        p1 = 300; step(0, 1, 0);
        settle(); check_const("score_998", int'(bus_if.score), 998);
        p1 = 100; p2 = 100; step(0, 1, 0);
        settle(); check_const("saturate_999", int'(bus_if.score), 999);
        p1 = 300; p2 = 300; step(0, 1, 0);
        p1 = 100; p2 = 100; step(0, 1, 0);
        settle(); check_const("stay_999", int'(bus_if.score), 999);

        // Collision and press together: collision wins.
        step(0, 0, 0);
        step(1, 0, 1);
        settle();
        check_const("col_press_state", int'(bus_if.state), 2);
        check_const("col_press_no_flap", int'(bus_if.flap_pulse), 0);
        for (int i = 0; i < DEATH_FRAMES - 1; i++) begin
            b = 1'($urandom_range(0, 1));
            step(b, 0, 1'($urandom_range(0, 1)));
            step(b, 1, 0);
        end
        settle(); check_const("dying_before_last", int'(bus_if.state), 2);
        step(0, 1, 0);
        settle();
        check_const("over_state", int'(bus_if.game_over), 1);
        check_const("over_high", int'(bus_if.high_score), 999);

        // OVER hold: early presses ignored.
        for (int i = 0; i < 10; i++) begin step(0, 1, 0); step(0, 0, 0); end
        step(1, 0, 0);
        settle(); check_const("over_press_f10", int'(bus_if.state), 3);
        step(0, 0, 0);
        for (int i = 10; i < OVER_HOLD - 1; i++) begin step(0, 1, 0); step(0, 0, 0); end
        step(1, 0, 0);
        settle(); check_const("over_press_f59", int'(bus_if.state), 3);
        step(0, 1, 0); step(0, 0, 0);
        step(1, 0, 0);
        settle();
        check_const("over_to_idle", int'(bus_if.state), 0);
        check_const("idle_score_held", int'(bus_if.score), 999);
        step(0, 0, 0); step(1, 0, 0);
        settle();
        check_const("restart_score", int'(bus_if.score), 0);
        check_const("restart_high", int'(bus_if.high_score), 999);

        // Asynchronous reset in the middle of DYING.
        step(0, 0, 1);
        step(0, 1, 0); step(0, 1, 0);
        do_reset(1'b0, 2, 1'b1);

        // Randomized play with scrolling pipes and occasional far-right respawns.
        p1 = 1280; p2 = 700; bx = 200; b = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            bit tick, col;
            if ($urandom_range(0, 7) == 0) b = ~b;
            tick = ($urandom_range(0, 3) == 0);
            col  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 499) == 0) bx = $urandom_range(0, 4095);
            step(b, tick, col);
            if (tick) begin
                p1 = (p1 < 25) ? (($urandom_range(0, 1) == 1) ? 1280 : $urandom_range(4016, 4095)) : p1 - $urandom_range(1, 24);
                p2 = (p2 < 25) ? (($urandom_range(0, 1) == 1) ? 1280 : $urandom_range(4016, 4095)) : p2 - $urandom_range(1, 24);
            end
        end

        settle(); settle();
        check_const("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
